// File: rtl/ula_sequencer_if.sv
// Request/response and ULA drive bundle for ula_sequencer.
// The initiator side uses 'master'. The sequencer uses 'slave'.
// The external ULA model or instance uses 'ula'.
interface ula_sequencer_if #(
    parameter int WIDTH = 8
);
    // request handshake
    logic                   Start;
    logic [2:0]             Op;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic                   Busy;
    logic                   Done;
    logic [2*WIDTH-1:0]     Result;
    logic                   Zero;
    logic                   Err;

    // ULA drive and return
    logic [WIDTH-1:0]       SrcA;
    logic [WIDTH-1:0]       SrcB;
    logic [2:0]             ULAControl;
    logic [WIDTH-1:0]       ULAResult;
    logic                   Z;

    modport master (
        output Start, Op, A, B,
        input  Busy, Done, Result, Zero, Err
    );

    modport slave (
        input  Start, Op, A, B, ULAResult, Z,
        output Busy, Done, Result, Zero, Err, SrcA, SrcB, ULAControl
    );

    modport ula (
        input  SrcA, SrcB, ULAControl,
        output ULAResult, Z
    );
endinterface

// File: rtl/ula_sequencer.sv
// Operation issuer for an external combinational ULA.
// Native ops take one ULA cycle.
// MUL is an unsigned shift-add that reuses the ULA adder for one iteration
// per cycle. The adder carry is recovered locally as (sum < Hi).
module ula_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    ula_sequencer_if.slave      bus
);
    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_ILL = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    // latched request
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [2:0]             r_op;

    // shift-add multiplier state: {Hi,Lo} is the running product
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;
    logic [WIDTH-1:0]       r_mcand;
    logic [CNT_W-1:0]       r_cnt;

    // response registers, held until the next DONE entry
    logic [2*WIDTH-1:0]     r_result;
    logic                   r_zero;
    logic                   r_err;

    // ULA drive
    logic [WIDTH-1:0]       w_src_a;
    logic [WIDTH-1:0]       w_src_b;
    logic [2:0]             w_ctl;

    // one multiply step
    logic                   w_carry;
    logic [WIDTH-1:0]       w_hi_nxt;
    logic [WIDTH-1:0]       w_lo_nxt;
    logic [2*WIDTH-1:0]     w_product;

    // State register. Reset always lands in IDLE, which also drops any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and ULA drive. The ULA sees zeros outside EXEC/MUL.
    always_comb begin
        w_state_nxt = r_state;
        w_src_a     = '0;
        w_src_b     = '0;
        w_ctl       = 3'b000;
        case (r_state)
            S_IDLE: begin
                if (bus.Start) begin
                    if (bus.Op == OP_MUL) begin
                        w_state_nxt = S_MUL;
                    end else if (bus.Op == OP_ILL) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                w_src_a     = r_a;
                w_src_b     = r_b;
                w_ctl       = r_op;
                w_state_nxt = S_DONE;
            end
            S_MUL: begin
                w_src_a = r_hi;
                w_src_b = r_lo[0] ? r_mcand : '0;
                w_ctl   = OP_ADD;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Start is deliberately ignored here; requests are not queued.
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // One shift-add step: the ULA sum wraps, so a sum below Hi means the add carried out.
    always_comb begin
        w_carry   = (bus.ULAResult < r_hi);
        {w_hi_nxt, w_lo_nxt} = {w_carry, bus.ULAResult, r_lo[WIDTH-1:1]};
        w_product = {w_hi_nxt, w_lo_nxt};
    end

    // Request latch, multiplier iteration and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 3'b000;
            r_hi     <= '0;
            r_lo     <= '0;
            r_mcand  <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Start) begin
                        r_a  <= bus.A;
                        r_b  <= bus.B;
                        r_op <= bus.Op;
                        if (bus.Op == OP_MUL) begin
                            r_hi    <= '0;
                            r_lo    <= bus.A;
                            r_mcand <= bus.B;
                            r_cnt   <= '0;
                        end else if (bus.Op == OP_ILL) begin
                            r_result <= '0;
                            r_zero   <= 1'b0;
                            r_err    <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    r_result <= {{WIDTH{1'b0}}, bus.ULAResult};
                    r_zero   <= bus.Z;
                    r_err    <= 1'b0;
                end
                S_MUL: begin
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_result <= w_product;
                        r_zero   <= (w_product == '0);
                        r_err    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.Busy       = (r_state != S_IDLE);
    assign bus.Done       = (r_state == S_DONE);
    assign bus.Result     = r_result;
    assign bus.Zero       = r_zero;
    assign bus.Err        = r_err;
    assign bus.SrcA       = w_src_a;
    assign bus.SrcB       = w_src_b;
    assign bus.ULAControl = w_ctl;

endmodule

// File: tb/tb_ula_sequencer.sv
// Directed bench for ula_sequencer with a behavioural 8-bit ULA attached.
module tb_ula_sequencer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ula_sequencer_if #(.WIDTH(8)) u_if ();

    ula_sequencer #(.WIDTH(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    // Behavioural ULA: combinational; SLT is an unsigned compare.
    logic [7:0] w_ula;
    always_comb begin
        w_ula = 8'h00;
        case (u_if.ULAControl)
            3'b000: w_ula = u_if.SrcA & u_if.SrcB;
            3'b001: w_ula = u_if.SrcA | u_if.SrcB;
            3'b010: w_ula = u_if.SrcA + u_if.SrcB;
            3'b011: w_ula = ~(u_if.SrcA | u_if.SrcB);
            3'b110: w_ula = u_if.SrcA - u_if.SrcB;
            3'b111: w_ula = {7'b0, (u_if.SrcA < u_if.SrcB)};
            default: w_ula = 8'h00;
        endcase
        u_if.ULAResult = w_ula;
        u_if.Z         = (w_ula == 8'h00);
    end

    int n_vec  = 0;
    int n_miss = 0;

    // cycle-1 snapshot and per-request observations from do_op
    logic [2:0] c1_ctl;
    logic [7:0] c1_sa;
    logic [7:0] c1_sb;
    logic       c1_busy;
    int         n_add;
    int         n_idle;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request at cycle 0, wait (bounded) for Done, check the response.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input int exp_lat, input logic [15:0] exp_res,
                         input logic exp_z, input logic exp_err);
        int cyc;
        bit got;
        @(negedge clk);
        u_if.Start = 1'b1;
        u_if.Op    = op;
        u_if.A     = a;
        u_if.B     = b;
        @(negedge clk);
        u_if.Start = 1'b0;
        u_if.Op    = 3'b000;
        u_if.A     = 8'h00;
        u_if.B     = 8'h00;
        c1_ctl  = u_if.ULAControl;
        c1_sa   = u_if.SrcA;
        c1_sb   = u_if.SrcB;
        c1_busy = u_if.Busy;
        n_add   = 0;
        n_idle  = 0;
        got     = 1'b0;
        cyc     = 1;
        while (cyc <= 20 && !got) begin
            if (u_if.ULAControl == 3'b010) n_add++;
            if (!u_if.Busy) n_idle++;
            if (u_if.Done) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!got) cyc = 0;
        chk_val({tag, "_latency"}, cyc, exp_lat);
        chk_val({tag, "_result"}, u_if.Result, exp_res);
        chk_val({tag, "_zero"}, u_if.Zero, exp_z);
        chk_val({tag, "_err"}, u_if.Err, exp_err);
        chk_val({tag, "_busy_thru"}, n_idle, 0);
        @(negedge clk);
        chk_val({tag, "_done_pulse"}, u_if.Done, 1'b0);
        chk_val({tag, "_busy_fall"}, u_if.Busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   ndone;
        int   dcyc;
        logic [15:0] cres;
        logic b10;

        rst        = 1'b1;
        u_if.Start = 1'b0;
        u_if.Op    = 3'b000;
        u_if.A     = 8'h00;
        u_if.B     = 8'h00;
        repeat (3) @(negedge clk);

        chk_val("rst_busy", u_if.Busy, 1'b0);
        chk_val("rst_done", u_if.Done, 1'b0);
        chk_val("rst_result", u_if.Result, 16'h0000);
        chk_val("rst_zero", u_if.Zero, 1'b0);
        chk_val("rst_err", u_if.Err, 1'b0);
        chk_val("rst_srca", u_if.SrcA, 8'h00);
        chk_val("rst_srcb", u_if.SrcB, 8'h00);
        chk_val("rst_ctl", u_if.ULAControl, 3'b000);

        // rst and Start in the same cycle: reset wins, nothing is latched
        u_if.Start = 1'b1;
        u_if.Op    = 3'b010;
        u_if.A     = 8'h01;
        u_if.B     = 8'h01;
        @(negedge clk);
        rst        = 1'b0;
        u_if.Start = 1'b0;
        chk_val("rst_wins_busy", u_if.Busy, 1'b0);
        @(negedge clk);
        chk_val("rst_wins_busy2", u_if.Busy, 1'b0);

        do_op("add", 3'b010, 8'h7F, 8'h01, 2, 16'h0080, 1'b0, 1'b0);
        chk_val("add_c1_ctl", c1_ctl, 3'b010);
        chk_val("add_c1_srca", c1_sa, 8'h7F);
        chk_val("add_c1_srcb", c1_sb, 8'h01);
        chk_val("add_c1_busy", c1_busy, 1'b1);

        do_op("sub", 3'b110, 8'h35, 8'h35, 2, 16'h0000, 1'b1, 1'b0);
        do_op("slt_ge", 3'b111, 8'h80, 8'h7F, 2, 16'h0000, 1'b1, 1'b0);
        do_op("slt_lt", 3'b111, 8'h01, 8'h02, 2, 16'h0001, 1'b0, 1'b0);
        do_op("and", 3'b000, 8'hF0, 8'h3C, 2, 16'h0030, 1'b0, 1'b0);
        do_op("or", 3'b001, 8'h0F, 8'hF0, 2, 16'h00FF, 1'b0, 1'b0);
        do_op("nor", 3'b011, 8'h0F, 8'hF0, 2, 16'h0000, 1'b1, 1'b0);

        do_op("mul_ff", 3'b100, 8'hFF, 8'hFF, 9, 16'hFE01, 1'b0, 1'b0);
        chk_val("mul_ff_add_cycles", n_add, 8);
        do_op("mul_zero", 3'b100, 8'h00, 8'h5A, 9, 16'h0000, 1'b1, 1'b0);
        do_op("mul_0d0b", 3'b100, 8'h0D, 8'h0B, 9, 16'h008F, 1'b0, 1'b0);

        do_op("illegal", 3'b101, 8'h12, 8'h34, 1, 16'h0000, 1'b0, 1'b1);
        chk_val("illegal_c1_ctl", c1_ctl, 3'b000);
        chk_val("illegal_c1_srca", c1_sa, 8'h00);
        chk_val("illegal_c1_srcb", c1_sb, 8'h00);
        chk_val("illegal_add_cycles", n_add, 0);

        // MUL with ADD Starts pulsed in cycles 3 and 9: both must be dropped
        @(negedge clk);
        u_if.Start = 1'b1;
        u_if.Op    = 3'b100;
        u_if.A     = 8'h10;
        u_if.B     = 8'h10;
        ndone = 0;
        dcyc  = 0;
        cres  = 16'h0000;
        b10   = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (u_if.Done) begin
                ndone++;
                dcyc = c;
                cres = u_if.Result;
            end
            if (c == 10) b10 = u_if.Busy;
            u_if.Start = (c == 3 || c == 9);
            u_if.Op    = 3'b010;
            u_if.A     = 8'h01;
            u_if.B     = 8'h01;
        end
        u_if.Start = 1'b0;
        chk_val("ign_done_count", ndone, 1);
        chk_val("ign_done_cycle", dcyc, 9);
        chk_val("ign_result", cres, 16'h0100);
        chk_val("ign_busy_c10", b10, 1'b0);
        do_op("after_ign", 3'b010, 8'h20, 8'h22, 2, 16'h0042, 1'b0, 1'b0);

        // MUL aborted by rst in cycle 4
        @(negedge clk);
        u_if.Start = 1'b1;
        u_if.Op    = 3'b100;
        u_if.A     = 8'h0D;
        u_if.B     = 8'h0B;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            u_if.Start = 1'b0;
            if (c == 4) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        chk_val("abort_busy", u_if.Busy, 1'b0);
        chk_val("abort_done", u_if.Done, 1'b0);
        chk_val("abort_result", u_if.Result, 16'h0000);
        chk_val("abort_err", u_if.Err, 1'b0);
        chk_val("abort_srca", u_if.SrcA, 8'h00);
        chk_val("abort_ctl", u_if.ULAControl, 3'b000);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (u_if.Done) ndone++;
        end
        chk_val("abort_no_done", ndone, 0);
        do_op("post_abort_add", 3'b010, 8'h02, 8'h03, 2, 16'h0005, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/ula_sequencer.md
# ula_sequencer

Operation issuer that sits on the initiator side of the 8-bit ULA. It accepts one request at a time over a Start/Busy/Done handshake and drives SrcA, SrcB and ULAControl into an external ULA instance. It captures ULAResult and Z, and returns a registered 16-bit Result. Native ULA ops complete in one ULA cycle. MUL is an 8-iteration shift-add that reuses the ULA adder, which lets the datapath multiply without a second arithmetic unit.

## Interface
- WIDTH, 8, operand width (ULA width); Result is 2*WIDTH

- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- Start  in  1  request strobe; sampled only when Busy=0
- Op  in  3  000 AND, 001 OR, 010 ADD, 011 NOR, 110 SUB, 111 SLT, 100 MUL, 101 illegal
- A, B  in  8 each  operands, sampled with Start
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse; Result/Zero/Err valid from this cycle
- Result  out  16  native ops: {8'h00, ULAResult}; MUL: unsigned product
- Zero  out  1  native ops: captured Z; MUL: product==0
- Err  out  1  high with Done for illegal Op, else low at Done
- SrcA, SrcB  out  8 each  to ULA
- ULAControl  out  3  to ULA
- ULAResult  in  8  from ULA (combinational from SrcA/SrcB/ULAControl)
- Z  in  1  from ULA

## Operation
- FSM states: IDLE, EXEC, MUL, DONE.
- IDLE:
  - Start=1 latches A→RegA, B→RegB, Op→RegOp.
  - Op native → EXEC; Op=100 → MUL with Hi=0, Lo=A, Mcand=B, Cnt=0; Op=101 → DONE with Err=1, Result=0, Zero=0.
  - No Start → stay.
- EXEC: drive SrcA=RegA, SrcB=RegB, ULAControl=RegOp. Capture Result={0,ULAResult}, Zero=Z, Err=0 at edge. → DONE.
- MUL, one iteration per cycle:
  - Drive SrcA=Hi, SrcB=Lo[0] ? Mcand : 0, ULAControl=010.
  - Carry = (ULAResult < Hi), unsigned, computed internally.
  - At edge: {Hi,Lo} ← {Carry, ULAResult, Lo[7:1]}; Cnt+1.
  - After 8th iteration (Cnt=7 at edge): Result={Hi',Lo'}, Zero=(product==0), Err=0. → DONE.
- DONE: Done=1 for this cycle only. Busy=1. → IDLE.
- Start while Busy=1 is ignored, including in DONE. It is not queued.
- When not in EXEC/MUL: SrcA=0, SrcB=0, ULAControl=000.
- Result, Zero and Err hold their last values until the next DONE entry.
- All arithmetic is unsigned. SLT reflects the ULA's unsigned compare. MUL overflow is impossible (16-bit product).

## Timing
- Reset values: state IDLE; Busy=0, Done=0, Result=0, Zero=0, Err=0, SrcA=0, SrcB=0, ULAControl=000; internal registers cleared.
- rst wins over Start in the same cycle.
- Cycle numbering: Start sampled at edge of cycle 0.
- Native op: EXEC is cycle 1, Done is cycle 2. Latency 2, so the earliest next Start is sampled in cycle 3.
- MUL: MUL state in cycles 1–8, Done in cycle 9. Latency 9.
- Illegal Op: DONE in cycle 1, so Done=1, Err=1 in cycle 1.
- Busy rises in cycle 1 and falls in the cycle after Done.
- rst mid-operation (EXEC/MUL/DONE):
  - Next cycle is IDLE with all reset values.
  - No Done pulse is produced for the aborted request.
  - The ULA drive returns to 0/000.
- ULA path is combinational within one cycle. No ULA pipelining is supported.

## Test plan
- ADD A=0x7F, B=0x01, Start at cycle 0 → ULAControl=010, SrcA=0x7F, SrcB=0x01 in cycle 1. Done in cycle 2 with Result=0x0080, Zero=0, Err=0. Busy high in cycles 1–2.
- SUB A=0x35, B=0x35 → Result=0x0000, Zero=1. Then SLT A=0x80, B=0x7F → Result=0x0000. Then SLT A=0x01, B=0x02 → Result=0x0001, Zero=0.
- MUL 0xFF×0xFF → ULAControl=010 for cycles 1–8, Done exactly in cycle 9, Result=0xFE01, Zero=0. MUL 0x00×0x5A → Result=0x0000, Zero=1. MUL 0x0D×0x0B → 0x008F.
- Op=101, A=0x12, B=0x34 → Done and Err both high in cycle 1, Result=0x0000, ULAControl stays 000 and SrcA/SrcB stay 0.
- MUL 0x10×0x10 started, Start with ADD pulsed in cycles 3 and 9 → both ignored. Single Done in cycle 9 with Result=0x0100. A subsequent Start accepted in IDLE works normally.
- MUL started, rst in cycle 4 → cycle 5 IDLE, Busy=0, Result=0, no Done pulse for ≥12 cycles. Then ADD 0x02+0x03 → Result=0x0005 with Done at latency 2.
